qam_symbol_slicer: RTL and testbench
====================================

// Module: qam_symbol_slicer
// PURPOSE
// - Downstream of the 16-QAM modem loopback top: consumes demultiplexed I/Q baseband samples (5Q12).
// - Integrate-and-dump over SPS samples per axis, then hard-decides to a 4-bit Gray-coded symbol.
// - The 4-bit symbol uses the same format as the modulator's din, so the bench can compare directly.
// - Decisions buffer in a small FIFO and are drained over a valid/ready interface.
// PARAMETERS
// - SPS         8           samples per symbol; power of 2, range 2..64
// - FIFO_DEPTH  4           symbol FIFO depth; power of 2, range >= 2
// - THRESH      18'sd8192   per-sample outer decision threshold, 5Q12 (2.0)
// - MARGIN      18'sd1024   per-sample low-confidence margin, 5Q12 (0.25); used only with the macro
// PORTS
// - axi_clk       in   1   clock
// - axi_rstn      in   1   asynchronous active-low reset
// - demult_valid  in   1   sample strobe (no backpressure; samples never stall)
// - demult_i      in   18  signed I sample, 5Q12
// - demult_q      in   18  signed Q sample, 5Q12
// - sym_align     in   1   1-cycle pulse marking the first sample of a symbol
// - dout_valid    out  1   FIFO not empty
// - dout          out  4   {i_bits[1:0], q_bits[1:0]} decided symbol
// - dout_ready    in   1   consumer accepts dout when dout_valid && dout_ready
// - overflow      out  1   sticky; a decision was dropped because the FIFO was full
// BEHAVIOUR
// - Reset (async assert, sync release): outputs are 0, state is WAIT_ALIGN, counter and accumulators are 0, FIFO is empty.
// - Accumulators are signed, width 18+log2(SPS); they never overflow.
// - Threshold T = THRESH*SPS, sign-extended to the accumulator width.
// - FSM WAIT_ALIGN: ignores samples until sym_align=1.
//   - If demult_valid is high in that same cycle, the sample is counted as sample 0.
//   - Next state is RUN.
// - FSM RUN: each valid sample adds to acc_i/acc_q and increments cnt.
//   - On the SPS-th sample (cnt=SPS-1), the final sum is registered into the decision stage, and acc/cnt restart at 0 on the next sample.
//   - There is no gap between symbols.
// - sym_align in RUN restarts alignment. The partial symbol is discarded and no decision is made for it.
//   - If demult_valid is high in the same cycle, that sample becomes sample 0.
// - Per-axis decision (a = final sum):
//   - a < -T        -> 2'b00
//   - -T <= a < 0   -> 2'b01
//   - 0 <= a < T    -> 2'b11
//   - a >= T        -> 2'b10
//   - Ties: a=0 resolves positive; a=T resolves outer.
// - Latency: sample SPS-1 accepted at cycle N -> decision registered at N+1 -> FIFO write at N+1 -> dout_valid=1 at N+2 (FIFO empty, no concurrent read).
// - FIFO write when full: the decision is dropped and overflow latches 1 until reset.
//   - Simultaneous read and write when full: the read frees a slot, so the write succeeds (no drop).
// - FIFO read on dout_valid && dout_ready.
//   - dout holds stable while dout_valid && !dout_ready.
//   - Simultaneous read and write when empty: no read occurs; the write lands and appears at N+2.
// - Pointers wrap modulo FIFO_DEPTH. Occupancy counter spans 0..FIFO_DEPTH.
// - Reset mid-symbol: all partial state is lost, and the FSM returns to WAIT_ALIGN.
// CONFIGURATION
// - Macro QAM_SLICER_CONF_EN: adds port low_conf_cnt (out, 16).
//   - It counts decided symbols where, on either axis, |a - t| < MARGIN*SPS for any t in {-T, 0, T}.
//   - The count saturates at 16'hFFFF and resets to 0.
// - Dropped symbols are still counted.
// - Without the macro: the port and logic are absent; decision behaviour is identical.
// TESTING (SPS=8, THRESH=8192, FIFO_DEPTH=4, dout_ready=1 unless stated)
// - Pulse sym_align, then 8 valid samples with i=+12288, q=-4096.
//   -> acc_i=98304, acc_q=-32768 -> dout=4'b1001, dout_valid high 2 cycles after the 8th sample.
// - Four symbols with i,q in {-12288,-4096,+4096,+12288} (i=-12288/q=+12288, i=-4096/q=+4096, i=+4096/q=-4096, i=+12288/q=-12288)
//   -> dout sequence 0010, 0111, 1101, 1000 in order.
// - Tie case: 8 samples with i=0, q=+8192 -> acc_i=0, acc_q=65536 -> dout=4'b1110.
// - dout_ready=0, 5 symbols in -> first 4 held in order, 5th dropped, overflow=1.
//   - Then raise dout_ready -> exactly 4 reads; overflow stays 1.
// - sym_align after 3 samples of a symbol -> no decision for the partial symbol; the next 8 samples yield one correct symbol.
// - Assert axi_rstn low mid-symbol with 2 entries in the FIFO -> dout_valid=0, overflow=0, and no output until a new sym_align.

Source files
------------

// File: rtl/qam_symbol_slicer.sv
// 16-QAM symbol slicer: integrate-and-dump over SPS samples per axis, Gray hard decision, decision FIFO.
// Optional QAM_SLICER_CONF_EN adds low_conf_cnt, a saturating count of decisions near a threshold.
module qam_symbol_slicer #(
  parameter int unsigned       SPS        = 8,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic signed [17:0] THRESH    = 18'sd8192
`ifdef QAM_SLICER_CONF_EN
  ,
  parameter logic signed [17:0] MARGIN    = 18'sd1024
`endif
) (
  input  logic               axi_clk,
  input  logic               axi_rstn,
  input  logic               demult_valid,
  input  logic signed [17:0] demult_i,
  input  logic signed [17:0] demult_q,
  input  logic               sym_align,
  output logic               dout_valid,
  output logic [3:0]         dout,
  input  logic               dout_ready,
  output logic               overflow
`ifdef QAM_SLICER_CONF_EN
  ,
  output logic [15:0]        low_conf_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(SPS);
  localparam int unsigned ACC_W = 18 + CNT_W;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  // Outer threshold scaled to a full-symbol sum
  localparam logic signed [ACC_W-1:0] T_POS = {{CNT_W{THRESH[17]}}, THRESH} <<< CNT_W;
  localparam logic signed [ACC_W-1:0] T_NEG = -T_POS;

  typedef enum logic [0:0] {
    ST_WAIT_ALIGN = 1'b0,
    ST_RUN        = 1'b1
  } state_t;

  function automatic logic [1:0] f_decide(input logic signed [ACC_W-1:0] a);
    logic [1:0] bits;
    if (a < T_NEG)      bits = 2'b00;
    else if (a < 0)     bits = 2'b01;
    else if (a < T_POS) bits = 2'b11;
    else                bits = 2'b10;
    return bits;
  endfunction

`ifdef QAM_SLICER_CONF_EN
  localparam int unsigned EXT_W = ACC_W + 2;
  localparam logic signed [EXT_W-1:0] T_EXT = {{2{T_POS[ACC_W-1]}}, T_POS};
  localparam logic signed [EXT_W-1:0] M_EXT = {{(CNT_W+2){MARGIN[17]}}, MARGIN} <<< CNT_W;

  // True when the sum sits strictly within the margin of -T, 0 or +T
  function automatic logic f_near(input logic signed [ACC_W-1:0] a);
    logic signed [EXT_W-1:0] ae;
    logic signed [EXT_W-1:0] d_neg;
    logic signed [EXT_W-1:0] d_pos;
    ae    = {{2{a[ACC_W-1]}}, a};
    d_neg = ae + T_EXT;
    d_pos = ae - T_EXT;
    return ((d_neg < M_EXT) && (d_neg > -M_EXT)) ||
           ((ae    < M_EXT) && (ae    > -M_EXT)) ||
           ((d_pos < M_EXT) && (d_pos > -M_EXT));
  endfunction
`endif

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_restart;
  logic                     w_accum;
  logic                     w_last;

  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc_i;
  logic signed [ACC_W-1:0]  r_acc_q;
  logic signed [ACC_W-1:0]  w_smp_i;
  logic signed [ACC_W-1:0]  w_smp_q;
  logic signed [ACC_W-1:0]  w_sum_i;
  logic signed [ACC_W-1:0]  w_sum_q;

  logic                     r_dec_vld;
  logic [3:0]               r_dec;

  logic [3:0]               r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [OCC_W-1:0]         r_occ;
  logic                     w_full;
  logic                     w_fifo_rd;
  logic                     w_fifo_wr;
  logic [PTR_W-1:0]         w_rd_ptr_nxt;
  logic [OCC_W-1:0]         w_occ_nxt;
  logic                     r_dout_valid;
  logic [3:0]               r_dout;
  logic                     r_overflow;

  assign w_smp_i = {{CNT_W{demult_i[17]}}, demult_i};
  assign w_smp_q = {{CNT_W{demult_q[17]}}, demult_q};
  assign w_sum_i = r_acc_i + w_smp_i;
  assign w_sum_q = r_acc_q + w_smp_q;

  // FSM state register
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) r_state <= ST_WAIT_ALIGN;
    else           r_state <= w_state_nxt;
  end

  // Next state and datapath strobes; sym_align always wins over a symbol completion
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_accum     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_WAIT_ALIGN: begin
        if (sym_align) begin
          w_restart   = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sym_align) begin
          w_restart = 1'b1;
        end else if (demult_valid) begin
          if (r_cnt == CNT_W'(SPS - 1)) w_last  = 1'b1;
          else                          w_accum = 1'b1;
        end
      end
      default: w_state_nxt = ST_WAIT_ALIGN;
    endcase
  end

  // Integrate-and-dump accumulators and decision stage
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_cnt     <= '0;
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      r_dec_vld <= 1'b0;
      r_dec     <= '0;
    end else begin
      r_dec_vld <= w_last;
      if (w_last) r_dec <= {f_decide(w_sum_i), f_decide(w_sum_q)};
      if (w_restart) begin
        r_cnt   <= demult_valid ? CNT_W'(1) : '0;
        r_acc_i <= demult_valid ? w_smp_i : '0;
        r_acc_q <= demult_valid ? w_smp_q : '0;
      end else if (w_last) begin
        r_cnt   <= '0;
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else if (w_accum) begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_acc_i <= w_sum_i;
        r_acc_q <= w_sum_q;
      end
    end
  end

  // A read in the same cycle frees a slot, so a full FIFO still accepts the write
  assign w_full       = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_fifo_rd    = (r_occ != '0) && dout_ready;
  assign w_fifo_wr    = r_dec_vld && (!w_full || w_fifo_rd);
  assign w_rd_ptr_nxt = w_fifo_rd ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
  assign w_occ_nxt    = r_occ + OCC_W'(w_fifo_wr) - OCC_W'(w_fifo_rd);

  always_ff @(posedge axi_clk) begin
    if (w_fifo_wr) r_mem[r_wr_ptr] <= r_dec;
  end

  // Pointers, occupancy and registered head; a write into an emptying FIFO bypasses the memory
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_occ        <= w_occ_nxt;
      r_dout_valid <= (w_occ_nxt != '0);
      if (w_fifo_wr && (r_wr_ptr == w_rd_ptr_nxt)) r_dout <= r_dec;
      else                                        r_dout <= r_mem[w_rd_ptr_nxt];
      if (r_dec_vld && !w_fifo_wr) r_overflow <= 1'b1;
    end
  end

  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;
  assign overflow   = r_overflow;

`ifdef QAM_SLICER_CONF_EN
  logic        r_dec_low;
  logic [15:0] r_low_conf_cnt;

  // Low-confidence flag travels with its decision; dropped decisions still count
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_dec_low      <= 1'b0;
      r_low_conf_cnt <= '0;
    end else begin
      if (w_last) r_dec_low <= f_near(w_sum_i) || f_near(w_sum_q);
      if (r_dec_vld && r_dec_low && (r_low_conf_cnt != 16'hFFFF))
        r_low_conf_cnt <= r_low_conf_cnt + 16'd1;
    end
  end

  assign low_conf_cnt = r_low_conf_cnt;
`endif

endmodule

// File: tb/tb_qam_symbol_slicer.sv
// Directed self-checking bench for qam_symbol_slicer (SPS=8, THRESH=2.0, FIFO_DEPTH=4).
module tb_qam_symbol_slicer;

  logic               axi_clk = 1'b0;
  logic               axi_rstn;
  logic               demult_valid;
  logic signed [17:0] demult_i;
  logic signed [17:0] demult_q;
  logic               sym_align;
  logic               dout_valid;
  logic [3:0]         dout;
  logic               dout_ready;
  logic               overflow;
`ifdef QAM_SLICER_CONF_EN
  logic [15:0]        low_conf_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] q_out [$];

  qam_symbol_slicer dut (
    .axi_clk      (axi_clk),
    .axi_rstn     (axi_rstn),
    .demult_valid (demult_valid),
    .demult_i     (demult_i),
    .demult_q     (demult_q),
    .sym_align    (sym_align),
    .dout_valid   (dout_valid),
    .dout         (dout),
    .dout_ready   (dout_ready),
    .overflow     (overflow)
`ifdef QAM_SLICER_CONF_EN
    ,
    .low_conf_cnt (low_conf_cnt)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  // Record every accepted output word
  always @(posedge axi_clk) begin
    if (axi_rstn && dout_valid && dout_ready) q_out.push_back(dout);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge axi_clk);
      #1;
    end
  endtask

  task automatic send_samples(input int n, input int i_val, input int q_val, input logic align_first);
    for (int k = 0; k < n; k++) begin
      demult_valid = 1'b1;
      demult_i     = 18'(i_val);
      demult_q     = 18'(q_val);
      sym_align    = (k == 0) && align_first;
      @(posedge axi_clk);
      #1;
    end
    demult_valid = 1'b0;
    sym_align    = 1'b0;
    demult_i     = '0;
    demult_q     = '0;
  endtask

  task automatic check_queue(input string tag, input int n,
                             input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] exp_v [4];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    check({tag, "_count"}, 32'(q_out.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_word%0d", tag, k),
            (k < q_out.size()) ? 32'(q_out[k]) : 32'hDEAD, 32'(exp_v[k]));
    end
  endtask

  initial begin
    axi_rstn     = 1'b0;
    demult_valid = 1'b0;
    demult_i     = '0;
    demult_q     = '0;
    sym_align    = 1'b0;
    dout_ready   = 1'b1;
    tick(2);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout",       32'(dout),       32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    axi_rstn = 1'b1;
    tick(1);

    // Samples before any sym_align are ignored
    send_samples(8, 12288, -4096, 1'b0);
    tick(3);
    check("no_align_count", 32'(q_out.size()), 32'd0);

    // Basic symbol and latency
    q_out.delete();
    send_samples(8, 12288, -4096, 1'b1);
    check("lat_n1_valid", 32'(dout_valid), 32'd0);
    tick(1);
    check("lat_n2_valid", 32'(dout_valid), 32'd1);
    check("lat_n2_dout",  32'(dout),       32'h9);
    tick(1);
    check("drain_valid",  32'(dout_valid), 32'd0);
    check_queue("basic", 1, 4'h9, 4'h0, 4'h0, 4'h0);

    // Four corner symbols back to back
    q_out.delete();
    send_samples(8, -12288,  12288, 1'b0);
    send_samples(8,  -4096,   4096, 1'b0);
    send_samples(8,   4096,  -4096, 1'b0);
    send_samples(8,  12288, -12288, 1'b0);
    tick(4);
    check_queue("corners", 4, 4'b0010, 4'b0111, 4'b1101, 4'b1000);

    // Ties: 0 resolves positive, +T outer, -T inner
    q_out.delete();
    send_samples(8,     0, 8192, 1'b0);
    send_samples(8, -8192,   -1, 1'b0);
    tick(4);
    check_queue("ties", 2, 4'b1110, 4'b0101, 4'h0, 4'h0);

    // Backpressure: four held, fifth dropped
    q_out.delete();
    dout_ready = 1'b0;
    send_samples(8, -12288,  12288, 1'b0);
    send_samples(8,  -4096,   4096, 1'b0);
    send_samples(8,   4096,  -4096, 1'b0);
    send_samples(8,  12288, -12288, 1'b0);
    tick(3);
    check("full_overflow", 32'(overflow),   32'd0);
    check("full_valid",    32'(dout_valid), 32'd1);
    check("full_head",     32'(dout),       32'b0010);
    send_samples(8, 12288, -4096, 1'b0);
    tick(3);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_head",     32'(dout),     32'b0010);
    dout_ready = 1'b1;
    tick(8);
    check_queue("drain", 4, 4'b0010, 4'b0111, 4'b1101, 4'b1000);
    check("drain_overflow", 32'(overflow),   32'd1);
    check("drain_empty",    32'(dout_valid), 32'd0);

    // Realignment discards a partial symbol
    q_out.delete();
    send_samples(3, 12288, 12288, 1'b1);
    send_samples(8, -4096, -12288, 1'b1);
    tick(4);
    check_queue("realign", 1, 4'b0100, 4'h0, 4'h0, 4'h0);

    // Reset mid-symbol with two FIFO entries
    q_out.delete();
    dout_ready = 1'b0;
    send_samples(8,  12288, -4096, 1'b0);
    send_samples(8, -12288, 12288, 1'b0);
    tick(3);
    check("pre_rst_valid", 32'(dout_valid), 32'd1);
    send_samples(3, 4096, 4096, 1'b0);
    axi_rstn = 1'b0;
    #2;
    check("mid_rst_valid",    32'(dout_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow),   32'd0);
    check("mid_rst_dout",     32'(dout),       32'd0);
    tick(1);
    axi_rstn   = 1'b1;
    dout_ready = 1'b1;
    send_samples(8, 12288, -4096, 1'b0);
    tick(4);
    check("post_rst_count", 32'(q_out.size()), 32'd0);
    check("post_rst_valid", 32'(dout_valid),   32'd0);
    send_samples(8, -4096, 4096, 1'b1);
    tick(4);
    check_queue("post_rst", 1, 4'b0111, 4'h0, 4'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
